// File: rtl/padin_filt_if.sv
// Pad-side bundle for padin_filt: raw pad bus in, filtered level and edge pulses out.
interface padin_filt_if #(
    parameter int M = 7,
    parameter int N = 0
);
    logic [M:N] PADPIN;
    logic [M:N] OUT0;
    logic [M:N] RISE;
    logic [M:N] FALL;
    logic       CHG;

    modport master (
        output PADPIN,
        input  OUT0,
        input  RISE,
        input  FALL,
        input  CHG
    );

    modport slave (
        input  PADPIN,
        output OUT0,
        output RISE,
        output FALL,
        output CHG
    );
endinterface

// File: rtl/padin_filt.sv
// Pad input conditioner: two-flop synchronizer, per-bit stability filter,
// and registered rise/fall/change pulses on every accepted level change.
module padin_filt #(
    parameter int M       = 7,
    parameter int N       = 0,
    parameter int FILT    = 3,
    parameter int CW      = 4,
    parameter bit RST_VAL = 1'b0
) (
    input logic         CLK,
    input logic         RESET,
    padin_filt_if.slave pad
);
    localparam int            W       = M - N + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [M:N]    s1_q, s2_q;
    logic [M:N]    out0_q, out0_d;
    logic [M:N]    rise_q, rise_d;
    logic [M:N]    fall_q, fall_d;
    logic          chg_q, chg_d;
    logic [CW-1:0] cnt_q [M:N];
    logic [CW-1:0] cnt_d [M:N];

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        out0_d = out0_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = N; i <= M; i++) begin
            cnt_d[i] = '0;
            // A bit that keeps disagreeing with OUT0 for FILT samples is accepted.
            if (s2_q[i] != out0_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out0_d[i] = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        chg_d = |(rise_d | fall_d);
    end

    // NOTE: state is updated with non-blocking assignments only; the counter array is
    // small and must start at zero, so it is reset along with everything else.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q   <= {W{RST_VAL}};
            s2_q   <= {W{RST_VAL}};
            out0_q <= {W{RST_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
            for (int i = N; i <= M; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= pad.PADPIN;
            s2_q   <= s1_q;
            out0_q <= out0_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pad.OUT0 = out0_q;
    assign pad.RISE = rise_q;
    assign pad.FALL = fall_q;
    assign pad.CHG  = chg_q;
endmodule

// File: tb/tb_padin_filt.sv
// Bench for padin_filt: three configurations share one pad stimulus and are
// compared against a sample-window model, a directed vector table and hand sequences.
module tb_padin_filt;
    logic       clk;
    logic       rst;
    logic [7:0] pad;
    int         n_vec;
    int         n_err;

    padin_filt_if #(.M(7), .N(0)) if_a ();
    padin_filt_if #(.M(7), .N(0)) if_b ();
    padin_filt_if #(.M(7), .N(0)) if_c ();

    assign if_a.PADPIN = pad;
    assign if_b.PADPIN = pad;
    assign if_c.PADPIN = pad;

    padin_filt #(.M(7), .N(0), .FILT(3), .CW(4), .RST_VAL(1'b0)) dut_a (
        .CLK(clk), .RESET(rst), .pad(if_a.slave));
    padin_filt #(.M(7), .N(0), .FILT(3), .CW(4), .RST_VAL(1'b1)) dut_b (
        .CLK(clk), .RESET(rst), .pad(if_b.slave));
    padin_filt #(.M(7), .N(0), .FILT(1), .CW(4), .RST_VAL(1'b0)) dut_c (
        .CLK(clk), .RESET(rst), .pad(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bit flips once its last FILT post-reset synchronized
    // samples all disagree with the current filtered level.
    int         m_filt [3] = '{3, 3, 1};
    logic [7:0] m_rstv [3] = '{8'h00, 8'hFF, 8'h00};
    logic [7:0] m_s1 [3];
    logic [7:0] m_s2 [3];
    logic [7:0] m_out [3];
    logic [7:0] m_rise [3];
    logic [7:0] m_fall [3];
    logic       m_chg [3];
    logic [7:0] m_hist [3][16];
    int         m_nh [3];

    task automatic model_edge(input logic r, input logic [7:0] p);
        logic [7:0] nxt;
        logic       flip;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_s1[k]   = m_rstv[k];
                m_s2[k]   = m_rstv[k];
                m_out[k]  = m_rstv[k];
                m_rise[k] = 8'h00;
                m_fall[k] = 8'h00;
                m_chg[k]  = 1'b0;
                m_nh[k]   = 0;
            end else begin
                for (int j = 15; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = m_s2[k];
                if (m_nh[k] < 16) m_nh[k]++;
                nxt = m_out[k];
                for (int i = 0; i < 8; i++) begin
                    flip = (m_nh[k] >= m_filt[k]);
                    for (int j = 0; j < m_filt[k]; j++)
                        if (m_hist[k][j][i] == m_out[k][i]) flip = 1'b0;
                    if (flip) nxt[i] = ~m_out[k][i];
                end
                m_rise[k] = nxt & ~m_out[k];
                m_fall[k] = ~nxt & m_out[k];
                m_chg[k]  = |(m_rise[k] | m_fall[k]);
                m_out[k]  = nxt;
                m_s2[k]   = m_s1[k];
                m_s1[k]   = p;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] p);
        @(negedge clk);
        rst = r;
        pad = p;
        @(posedge clk);
        model_edge(r, p);
        #1;
        check("model_a", {7'd0, if_a.OUT0, if_a.RISE, if_a.FALL, if_a.CHG},
              {7'd0, m_out[0], m_rise[0], m_fall[0], m_chg[0]});
        check("model_b", {7'd0, if_b.OUT0, if_b.RISE, if_b.FALL, if_b.CHG},
              {7'd0, m_out[1], m_rise[1], m_fall[1], m_chg[1]});
        check("model_c", {7'd0, if_c.OUT0, if_c.RISE, if_c.FALL, if_c.CHG},
              {7'd0, m_out[2], m_rise[2], m_fall[2], m_chg[2]});
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] pad;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [7:0] p, input logic [7:0] o,
                       input logic [7:0] ri, input logic [7:0] fa, input logic c);
        vec_t v;
        v = '{rst: r, pad: p, out: o, rise: ri, fall: fa, chg: c};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int hold;
        logic [7:0] p;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        pad   = 8'h00;

        // Directed table against the FILT=3, RST_VAL=0 instance (edges after release).
        add(2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);  // reset
        add(2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);  // edges 1-2
        add(2, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);  // edges 3-4: two-cycle glitch
        add(5, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);  // edges 5-9
        add(4, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);  // edges 10-13
        add(1, 0, 8'h01, 8'h01, 8'h01, 8'h00, 1);  // edge 14
        add(1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0);  // edge 15
        add(4, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0);  // edges 16-19
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1);  // edge 20
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);  // edge 21
        add(4, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 0);  // edges 22-25
        add(1, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1);  // edge 26
        add(1, 0, 8'hA5, 8'hA5, 8'h00, 8'h00, 0);  // edge 27
        add(4, 0, 8'h0F, 8'hA5, 8'h00, 8'h00, 0);  // edges 28-31
        add(1, 0, 8'h0F, 8'h0F, 8'h0A, 8'hA0, 1);  // edge 32
        add(1, 0, 8'h0F, 8'h0F, 8'h00, 8'h00, 0);  // edge 33
        add(3, 0, 8'h07, 8'h0F, 8'h00, 8'h00, 0);  // edges 34-36: bit3 counting
        add(1, 1, 8'h07, 8'h00, 8'h00, 8'h00, 0);  // edge 37: reset mid-count
        add(4, 0, 8'h07, 8'h00, 8'h00, 8'h00, 0);  // edges 38-41
        add(1, 0, 8'h07, 8'h07, 8'h07, 8'h00, 1);  // edge 42
        add(1, 0, 8'h07, 8'h07, 8'h00, 8'h00, 0);  // edge 43

        foreach (tbl[v]) begin
            step(tbl[v].rst, tbl[v].pad);
            check($sformatf("row%0d_out", v), {24'd0, if_a.OUT0}, {24'd0, tbl[v].out});
            check($sformatf("row%0d_pulse", v), {15'd0, if_a.RISE, if_a.FALL, if_a.CHG},
                  {15'd0, tbl[v].rise, tbl[v].fall, tbl[v].chg});
        end

        // RST_VAL=1 with pads low, then a FILT=1 pass-through change.
        step(1, 8'h00);
        step(1, 8'h00);
        for (int e = 1; e <= 14; e++) begin
            step(0, (e >= 7 && e <= 10) ? 8'h3C : 8'h00);
            if (e <= 6) begin
                check("b_out", {24'd0, if_b.OUT0}, (e < 5) ? 32'hFF : 32'h00);
                check("b_fall", {24'd0, if_b.FALL}, (e == 5) ? 32'hFF : 32'h00);
                check("b_chg", {31'd0, if_b.CHG}, {31'd0, e == 5});
            end
            if (e >= 7) begin
                check("c_out", {24'd0, if_c.OUT0}, (e >= 9 && e <= 12) ? 32'h3C : 32'h00);
                check("c_rise", {24'd0, if_c.RISE}, (e == 9) ? 32'h3C : 32'h00);
                check("c_fall", {24'd0, if_c.FALL}, (e == 13) ? 32'h3C : 32'h00);
            end
        end

        // Random holds, single-bit glitches and occasional resets against the model.
        p = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                step(1, 8'($urandom));
            end else begin
                if ($urandom_range(0, 2) == 0) p = p ^ (8'h01 << $urandom_range(0, 7));
                else p = 8'($urandom);
                hold = $urandom_range(1, 6);
                for (int h = 0; h < hold; h++) step(0, p);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/padin_filt.md
PADIN_FILT -- requirements
Module: padin_filt

Interface
REQ-001 Parameter M, default 7: MSB index of pad bus.
REQ-002 Parameter N, default 0: LSB index of pad bus.
REQ-003 Parameter FILT, default 3: consecutive stable sample cycles required before a bit change is accepted; legal range 1..(2**CW)-1.
REQ-004 Parameter CW, default 4: per-bit filter counter width.
REQ-005 Parameter RST_VAL, default 0: reset level of synchronizer and filtered outputs, all bits.
REQ-006 CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 RESET  input  1  synchronous, active-high reset.
REQ-008 PADPIN  input  [M:N]  asynchronous pad bus from the input pad ring.
REQ-009 OUT0  output  [M:N]  synchronized, glitch-filtered pad level.
REQ-010 RISE  output  [M:N]  per-bit one-cycle pulse on accepted 0->1 change of OUT0.
REQ-011 FALL  output  [M:N]  per-bit one-cycle pulse on accepted 1->0 change of OUT0.
REQ-012 CHG  output  1  one-cycle pulse when any OUT0 bit changes (OR of RISE|FALL, registered alongside them).

Function
REQ-013 Two-flop synchronizer per bit: S1 <= PADPIN, S2 <= S1; no logic between S1 and S2.
REQ-014 Per-bit counter CNT[CW-1:0]: if S2[i]==OUT0[i], CNT <= 0; else if CNT==FILT-1, OUT0[i] <= S2[i] and CNT <= 0; else CNT <= CNT+1.
REQ-015 Acceptance latency: a PADPIN level captured into S1 at edge k and held appears on OUT0 at edge k+1+FILT (FILT=3 -> edge k+4).
REQ-016 Any return of S2[i] to OUT0[i] before acceptance clears CNT; no OUT0 change, no pulse (glitch of <FILT cycles at S2 is rejected).
REQ-017 RISE[i]/FALL[i]/CHG registered in the same edge OUT0[i] updates; high exactly one cycle; deasserted next edge unless another bit is accepted then.
REQ-018 Bits are fully independent; simultaneous acceptance on several bits asserts each corresponding RISE/FALL bit in the same cycle and a single CHG pulse.
REQ-019 RISE and FALL of the same bit never assert together.
REQ-020 CNT never exceeds FILT-1; no wrap-around path.
REQ-021 FILT=1: OUT0 follows S2 with one extra register stage, no filtering beyond synchronizer.
REQ-022 Pad change of a bit while its CNT is mid-count toward the opposite level: counter clears per REQ-014, restarts on next mismatch.

Reset
REQ-023 RESET high at an edge: S1, S2, OUT0 <= {RST_VAL}; CNT <= 0; RISE, FALL, CHG <= 0; reset has priority over all updates.
REQ-024 No RISE/FALL/CHG pulse in the cycle after reset release, even if PADPIN differs from RST_VAL; such a difference is accepted per REQ-015 with timing counted from the first post-reset sample.
REQ-025 RESET asserted mid-count discards pending acceptance; no pulse emitted.

Verification
REQ-026 FILT=3, reset, PADPIN=8'h00, then 8'h01 from edge 10 held -> OUT0=8'h01 at edge 14, RISE=8'h01 and CHG=1 for edge 14 only.
REQ-027 FILT=3, OUT0=8'h00, PADPIN bit0 high for 2 cycles then low -> OUT0 stays 8'h00, RISE/CHG never assert.
REQ-028 FILT=3, PADPIN 8'h00 -> 8'hA5 in one cycle -> at latency edge OUT0=8'hA5, RISE=8'hA5, FALL=8'h00, single CHG pulse; then 8'hA5 -> 8'h0F -> RISE=8'h0A, FALL=8'hA0 same cycle.
REQ-029 FILT=3, bit3 change held, RESET asserted at edge 2 of count -> OUT0 = RST_VAL, no FALL/RISE; after release, change accepted 1+FILT edges after first sample.
REQ-030 RST_VAL=1, PADPIN=8'h00 during and after reset -> no pulse in first post-reset cycle; FALL=8'hFF at edge 1+FILT after release.
REQ-031 FILT=1 -> held change appears on OUT0 two edges after capture into S1, with matching one-cycle RISE/FALL.
